// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen
// Description : Programmable pulse train source. A start strobe latches the
//               delay / period / pulse count and emits single-cycle pulses:
//               the first after 'delay' cycles, then one every max(period,2)
//               cycles. Reports busy, a done strobe and a running pulse count.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [NUM_WIDTH-1:0] num_pulses,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_WIDTH-1:0] pulse_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);
  localparam logic [NUM_WIDTH-1:0] NUM_ZERO = '0;
  localparam logic [NUM_WIDTH-1:0] NUM_ONE  = NUM_WIDTH'(1);

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_tcnt;      // cycles remaining in DELAY/GAP minus one
  logic [CNT_WIDTH-1:0] r_gap_load;  // clamped period minus two
  logic [NUM_WIDTH-1:0] r_left;      // pulses still to emit, including current

  logic [2:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] w_tcnt_nxt;
  logic [CNT_WIDTH-1:0] w_gap_load_nxt;
  logic [NUM_WIDTH-1:0] w_left_nxt;
  logic                 w_start_ok;

  logic                 w_pulse_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [NUM_WIDTH-1:0] w_cnt_nxt;

  // State, timing counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tcnt     <= CNT_ZERO;
      r_gap_load <= CNT_ZERO;
      r_left     <= NUM_ZERO;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pulse_cnt  <= NUM_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_gap_load <= w_gap_load_nxt;
      r_left     <= w_left_nxt;
      pulse_out  <= w_pulse_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
      pulse_cnt  <= w_cnt_nxt;
    end
  end

  // Next-state and counter update; DELAY lasts 'delay' cycles and GAP lasts
  // P-1 cycles so pulses land exactly P cycles apart
  always_comb begin
    w_state_nxt    = r_state;
    w_tcnt_nxt     = r_tcnt;
    w_gap_load_nxt = r_gap_load;
    w_left_nxt     = r_left;
    w_start_ok     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_start_ok     = 1'b1;
          w_gap_load_nxt = (period < CNT_TWO) ? CNT_ZERO : (period - CNT_TWO);
          w_left_nxt     = num_pulses;
          if (num_pulses == NUM_ZERO) begin
            w_state_nxt = ST_DONE;
          end else if (delay == CNT_ZERO) begin
            w_state_nxt = ST_PULSE;
          end else begin
            w_state_nxt = ST_DELAY;
            w_tcnt_nxt  = delay - CNT_ONE;
          end
        end
      end
      ST_DELAY, ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == CNT_ZERO) begin
          w_state_nxt = ST_PULSE;
        end else begin
          w_tcnt_nxt = r_tcnt - CNT_ONE;
        end
      end
      ST_PULSE: begin
        w_left_nxt = r_left - NUM_ONE;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_left == NUM_ONE) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_GAP;
          w_tcnt_nxt  = r_gap_load;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state; the pulse count advances the cycle
  // after each emitted pulse, so a pulse coinciding with abort is still counted
  always_comb begin
    w_pulse_nxt = (w_state_nxt == ST_PULSE);
    w_busy_nxt  = (w_state_nxt == ST_DELAY) || (w_state_nxt == ST_PULSE) ||
                  (w_state_nxt == ST_GAP);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    if (w_start_ok) begin
      w_cnt_nxt = NUM_ZERO;
    end else if (pulse_out) begin
      w_cnt_nxt = pulse_cnt + NUM_ONE;
    end else begin
      w_cnt_nxt = pulse_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_train_gen
// Description : Self-checking bench for pulse_train_gen. Expected outputs come
//               from an arithmetic model of the pulse schedule (start cycle,
//               delay, clamped period, count) evaluated every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

  localparam int CW = 32;
  localparam int NW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] delay;
  logic [CW-1:0] period;
  logic [NW-1:0] num_pulses;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [NW-1:0] pulse_cnt;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  // Reference model state: one active train described by its parameters
  bit     m_act  = 1'b0;
  longint m_s    = 0;
  longint m_d    = 0;
  longint m_p    = 2;
  longint m_n    = 0;
  longint m_hold = 0;

  pulse_train_gen #(.CNT_WIDTH(CW), .NUM_WIDTH(NW)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .delay      (delay),
    .period     (period),
    .num_pulses (num_pulses),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Pulses of the active train whose cycle (relative to start) is <= r
  function automatic longint pulses_upto(input longint r);
    longint k;
    if (m_n == 0 || r < 1 + m_d) return 0;
    k = (r - 1 - m_d) / m_p + 1;
    return (k > m_n) ? m_n : k;
  endfunction

  // Check the current cycle, apply inputs for it, update the model, advance
  task automatic step(input bit st, input bit ab, input bit rs,
                      input logic [CW-1:0] d, input logic [CW-1:0] p,
                      input logic [NW-1:0] n);
    longint rel, last, donec, cnt;
    bit e_pulse, e_busy, e_done;
    rel = 0; e_pulse = 0; e_busy = 0; e_done = 0; cnt = m_hold;
    if (m_act) begin
      rel   = cyc - m_s;
      last  = 1 + m_d + (m_n - 1) * m_p;
      donec = (m_n == 0) ? 1 : last + 1;
      e_pulse = (m_n > 0) && (rel >= 1 + m_d) && (rel <= last) && (((rel - 1 - m_d) % m_p) == 0);
      e_busy  = (m_n > 0) && (rel >= 1) && (rel <= last);
      e_done  = (rel == donec);
      cnt     = pulses_upto(rel - 1);
    end
    check_val("pulse_out", {63'd0, pulse_out}, {63'd0, e_pulse});
    check_val("busy",      {63'd0, busy},      {63'd0, e_busy});
    check_val("done",      {63'd0, done},      {63'd0, e_done});
    check_val("pulse_cnt", {48'd0, pulse_cnt}, cnt);

    rst_n = rs; start = st; abort = ab; delay = d; period = p; num_pulses = n;

    if (!rs) begin
      m_act = 1'b0; m_hold = 0;
    end else if (m_act) begin
      if (ab && e_busy) begin
        m_act = 1'b0; m_hold = pulses_upto(rel);
      end else if (e_done) begin
        m_act = 1'b0; m_hold = m_n;
      end
    end else if (st && !ab) begin
      m_act = 1'b1; m_s = cyc;
      m_d = longint'(d);
      m_p = (p < 2) ? 2 : longint'(p);
      m_n = longint'(n);
    end

    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // Idle cycles with scrambled config inputs, which must not disturb a train
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b0, 1'b0, 1'b1, CW'($urandom), CW'($urandom), NW'($urandom));
  endtask

  task automatic go(input logic [CW-1:0] d, input logic [CW-1:0] p, input logic [NW-1:0] n);
    step(1'b1, 1'b0, 1'b1, d, p, n);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    delay = '0; period = '0; num_pulses = '0;
    @(posedge clk_in);
    #1;
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);

    // Basic train
    go(3, 5, 4); idle(25);
    check_val("t1_final_cnt", {48'd0, pulse_cnt}, 64'd4);

    // Empty train
    go(3, 5, 0); idle(5);

    // Period clamping, zero delay
    go(0, 0, 3); idle(8);
    go(0, 1, 3); idle(8);

    // Abort during gap, then abort on a pulse cycle
    go(3, 5, 4); idle(7); step(1'b0, 1'b1, 1'b1, 0, 0, 0); idle(15);
    check_val("t4_abort_cnt", {48'd0, pulse_cnt}, 64'd2 - 64'd1);
    go(3, 5, 4); idle(8); step(1'b0, 1'b1, 1'b1, 0, 0, 0); idle(15);

    // Start while busy is ignored; start with abort in IDLE is ignored
    go(3, 5, 4); idle(5); go(1, 1, 1); idle(20);
    step(1'b1, 1'b1, 1'b1, 2, 3, 2); idle(10);

    // Abort in DONE cycle has no effect on done
    go(1, 2, 1); idle(2); step(1'b0, 1'b1, 1'b1, 0, 0, 0); idle(3);

    // Reset mid-train, then a fresh train
    go(3, 5, 4); idle(9); step(1'b0, 1'b0, 1'b0, 0, 0, 0); idle(9);
    go(3, 5, 4); idle(25);

    // Maximum delay: stays in delay without wrap, then aborted
    go({CW{1'b1}}, 3, 2); idle(40); step(1'b0, 1'b1, 1'b1, 0, 0, 0); idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 99) != 0),
           CW'($urandom_range(0, 12)), CW'($urandom_range(0, 6)),
           NW'($urandom_range(0, 5)));
    end
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
